// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback
// for R-type, lw/sw, beq, j, addi/andi, and traps on anything else.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic [5:0]       alu_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_IMM_EXEC = 4'd10;
    localparam logic [3:0] S_IMM_WB   = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b000100;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             funct_ok;
    logic             retire;

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100111, 6'b101010, 6'b100110: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_d = funct_ok ? S_EXEC : S_TRAP;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_IMM_EXEC;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_IMM_EXEC: state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Only completing states ever lead back to FETCH, so any re-entry retires one instruction.
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        alu_sel    = 6'b000000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_sel   = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_sel   = ALU_ADD;
            end
            S_MEM_ADDR, S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = opcode;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_sel   = funct;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = alu_zero;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_IMM_WB: reg_write = 1'b1;
            default: ;
        endcase
        // Reset silences every strobe immediately, not just from the next edge.
        if (rst) begin
            alu_sel    = 6'b000000;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            ir_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into the
// cycle-by-cycle plan an instruction of its class must follow, with random memory waits.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode, funct;
    logic          alu_zero, mem_ready;
    logic [5:0]    alu_sel;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          ir_write, iord, mem_read, mem_write;
    logic          reg_write, reg_dst, mem_to_reg;
    logic [3:0]    state;
    logic          illegal;
    logic [CW-1:0] instr_count;
    logic [18:0]   ctrlVec;

    int         vectors = 0;
    int         miscompares = 0;
    int         expCount = 0;
    logic       expIllegal = 1'b0;
    logic [5:0] curOp = 6'd0;
    logic [5:0] curFn = 6'd0;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctrlVec = {alu_sel, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                      iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg};

    // Control word each state must present, straight from the state table.
    function automatic logic [18:0] expOut(input logic [3:0] s, input logic rdy,
                                           input logic z, input logic [5:0] op,
                                           input logic [5:0] fn);
        logic [5:0] sel = 6'd0;
        logic       a = 1'b0;
        logic [1:0] b = 2'b00;
        logic       pcw = 1'b0;
        logic [1:0] ps = 2'b00;
        logic       irw = 1'b0, io = 1'b0, mrd = 1'b0, mwr = 1'b0;
        logic       rw = 1'b0, rd = 1'b0, m2r = 1'b0;
        case (s)
            4'd0:  begin mrd = 1; b = 2'b01; sel = 6'b100000; irw = rdy; pcw = rdy; end
            4'd1:  begin b = 2'b11; sel = 6'b100000; end
            4'd2:  begin a = 1; b = 2'b10; sel = op; end
            4'd3:  begin mrd = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; io = 1; end
            4'd6:  begin a = 1; sel = fn; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin a = 1; sel = 6'b000100; ps = 2'b01; pcw = z; end
            4'd9:  begin ps = 2'b10; pcw = 1; end
            4'd10: begin a = 1; b = 2'b10; sel = op; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {sel, a, b, pcw, ps, irw, io, mrd, mwr, rw, rd, m2r};
    endfunction

    function automatic logic isLegalFunct(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 || fn == 6'b100101 ||
               fn == 6'b100111 || fn == 6'b101010 || fn == 6'b100110;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] expState, input logic rdy, input logic z);
        @(negedge clk);
        rst = 1'b0; opcode = curOp; funct = curFn; alu_zero = z; mem_ready = rdy;
        #1;
        checkOutput("state", 32'(state), 32'(expState));
        checkOutput("ctrl", 32'(ctrlVec), 32'(expOut(expState, rdy, z, curOp, curFn)));
        checkOutput("illegal", 32'(illegal), 32'(expIllegal));
        checkOutput("instr_count", 32'(instr_count), 32'(expCount));
        checkOutput("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        checkOutput("pcw_rw_excl", 32'(pc_write & reg_write), 32'd0);
        @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'($urandom); alu_zero = 1'($urandom);
        #1;
        checkOutput("rst_ctrl", 32'(ctrlVec), 32'd0);
        @(posedge clk);
        expCount   = 0;
        expIllegal = 1'b0;
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fetchWait, input int memWait);
        logic trapped = 1'b0;
        curOp = op;
        curFn = fn;
        for (int i = 0; i < fetchWait; i++) applyStimulus(4'd0, 1'b0, 1'($urandom));
        applyStimulus(4'd0, 1'b1, 1'($urandom));
        applyStimulus(4'd1, 1'($urandom), 1'($urandom));
        if (op == 6'b000000 && isLegalFunct(fn)) begin
            applyStimulus(4'd6, 1'($urandom), 1'($urandom));
            applyStimulus(4'd7, 1'($urandom), 1'($urandom));
        end else if (op == 6'b100011) begin
            applyStimulus(4'd2, 1'($urandom), 1'($urandom));
            for (int i = 0; i < memWait; i++) applyStimulus(4'd3, 1'b0, 1'($urandom));
            applyStimulus(4'd3, 1'b1, 1'($urandom));
            applyStimulus(4'd4, 1'($urandom), 1'($urandom));
        end else if (op == 6'b101011) begin
            applyStimulus(4'd2, 1'($urandom), 1'($urandom));
            for (int i = 0; i < memWait; i++) applyStimulus(4'd5, 1'b0, 1'($urandom));
            applyStimulus(4'd5, 1'b1, 1'($urandom));
        end else if (op == 6'b000100) begin
            applyStimulus(4'd8, 1'($urandom), z);
        end else if (op == 6'b000010) begin
            applyStimulus(4'd9, 1'($urandom), 1'($urandom));
        end else if (op == 6'b001000 || op == 6'b001100) begin
            applyStimulus(4'd10, 1'($urandom), 1'($urandom));
            applyStimulus(4'd11, 1'($urandom), 1'($urandom));
        end else begin
            trapped = 1'b1;
        end
        if (trapped || op == 6'b000000 && !isLegalFunct(fn)) begin
            expIllegal = 1'b1;
            for (int i = 0; i < 11; i++) applyStimulus(4'd12, 1'($urandom), 1'($urandom));
            doReset();
        end else begin
            expCount = (expCount + 1) % (1 << CW);
        end
    endtask

    initial begin
        logic [5:0] opTable [9];
        logic [5:0] fnTable [8];
        logic [5:0] op, fn;
        opTable = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                    6'b000010, 6'b001000, 6'b001100, 6'b111111};
        fnTable = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100111, 6'b101010, 6'b100110, 6'b000000};
        rst = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        runInstr(6'b000000, 6'b100000, 1'b0, 0, 0);
        runInstr(6'b100011, 6'b000000, 1'b0, 0, 3);
        runInstr(6'b000100, 6'b000000, 1'b1, 0, 0);
        runInstr(6'b000100, 6'b000000, 1'b0, 1, 0);
        runInstr(6'b111111, 6'b000000, 1'b0, 0, 0);
        runInstr(6'b000000, 6'b000000, 1'b0, 0, 0);

        for (int i = 0; i < 16; i++) runInstr(6'b001000, 6'($urandom), 1'b0, 0, 0);
        applyStimulus(4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = opTable[$urandom_range(0, 8)];
            fn = (op == 6'b000000) ? fnTable[$urandom_range(0, 7)] : 6'($urandom);
            runInstr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Store abandoned by reset while waiting on memory.
        runInstr(6'b000000, 6'b100101, 1'b0, 0, 0);
        curOp = 6'b101011;
        curFn = 6'b000000;
        applyStimulus(4'd0, 1'b1, 1'b0);
        applyStimulus(4'd1, 1'b0, 1'b0);
        applyStimulus(4'd2, 1'b0, 1'b0);
        applyStimulus(4'd5, 1'b0, 1'b0);
        applyStimulus(4'd5, 1'b0, 1'b0);
        doReset();
        applyStimulus(4'd0, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
